id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register for the 5-stage RV32I core. Captures the register-file

---
 rtl/riscv_pipe_pkg.sv | 51 +++++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: register index width,
// packed control word layout, result/ALU encodings and the NOP control word.
package riscv_pipe_pkg;

    localparam int REG_W  = 5;
    localparam int CTRL_W = 11;

    // Control word, MSB first. The bit offsets below must match this order.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] result_src;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       branch;
        logic       jump;
    } ctrl_t;

    localparam int CTRL_JUMP        = 0;
    localparam int CTRL_BRANCH      = 1;
    localparam int CTRL_ALU_CTRL_LO = 2;
    localparam int CTRL_ALU_SRC     = 5;
    localparam int CTRL_RES_SRC_LO  = 6;
    localparam int CTRL_MEM_READ    = 8;
    localparam int CTRL_MEM_WRITE   = 9;
    localparam int CTRL_REG_WRITE   = 10;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    // All-zero control: no register write, no memory access.
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] c);
        ctrl_t f;
        f = ctrl_t'(c);
        return f.mem_read;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the instruction in EX and the one in ID.
// Purely combinational so other stall sources can be OR-ed in by the caller.
module hazard_detect
    import riscv_pipe_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             load_use
);

    logic hit_rs1;
    logic hit_rs2;

    // A load writing x0 never produces data anyone waits on.
    always_comb begin
        hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
        hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                   (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands, immediate, PCs and control,
// freezes IF/ID on a load-use hazard and counts inserted bubbles.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_e,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_pc4,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_pc4,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_f,
    output logic              stall_d,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic              vld_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [XLEN-1:0]   pc4_p1;
    logic [REG_W-1:0]  rs1_p1;
    logic [REG_W-1:0]  rs2_p1;
    logic [REG_W-1:0]  rd_p1;
    logic [XLEN-1:0]   rd1_p1;
    logic [XLEN-1:0]   rd2_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              load_use;
    logic              bubble;

    hazard_detect u_hazard (
        .ex_valid    (vld_p1),
        .ex_mem_read (ctrl_is_load(ctrl_p1)),
        .ex_rd       (rd_p1),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .load_use    (load_use)
    );

    // A flush squashes the ID instruction upstream, so it masks the stall;
    // reset also forces the stalls low while EX is being cleared.
    always_comb begin
        bubble  = flush_e || load_use;
        stall_f = load_use && !flush_e && !rst;
        stall_d = stall_f;
    end

    // ---- ID -> EX boundary ----
    // Pipeline register: bubble on flush or load-use, otherwise capture ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            vld_p1  <= 1'b0;
            pc_p1   <= '0;
            pc4_p1  <= '0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            rd_p1   <= '0;
            rd1_p1  <= '0;
            rd2_p1  <= '0;
            imm_p1  <= '0;
            ctrl_p1 <= CTRL_NOP;
        end else begin
            vld_p1  <= id_valid;
            pc_p1   <= id_pc;
            pc4_p1  <= id_pc4;
            rs1_p1  <= id_rs1;
            rs2_p1  <= id_rs2;
            rd_p1   <= id_rd;
            rd1_p1  <= id_rd1;
            rd2_p1  <= id_rd2;
            imm_p1  <= id_imm;
            ctrl_p1 <= id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    // Saturating count of every bubble loaded into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (bubble) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign ex_valid   = vld_p1;
    assign ex_pc      = pc_p1;
    assign ex_pc4     = pc4_p1;
    assign ex_rs1     = rs1_p1;
    assign ex_rs2     = rs2_p1;
    assign ex_rd      = rd_p1;
    assign ex_rd1     = rd1_p1;
    assign ex_rd2     = rd2_p1;
    assign ex_imm     = imm_p1;
    assign ex_ctrl    = ctrl_p1;
    assign bubble_cnt = cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stall, non-hazards,
// flush priority, async reset and bubble counter saturation (CNT_W = 2).
module tb_id_ex_stage;
    import riscv_pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    // Hand-built control words (layout: rw mw mr rs[1:0] as ac[2:0] br j)
    localparam logic [CTRL_W-1:0] C_ADD = 11'h400;  // reg_write only
    localparam logic [CTRL_W-1:0] C_LW  = 11'h560;  // reg_write|mem_read|res=MEM|alu_src

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_e;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall_f, stall_d;
    logic [CNT_W-1:0]  bubble_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_e(flush_e), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_f(stall_f), .stall_d(stall_d),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic u1, input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic [CTRL_W-1:0] c);
        id_valid   = v;
        id_pc      = pc;
        id_pc4     = pc + 32'd4;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        id_rd      = rd;
        id_ctrl    = c;
    endtask

    initial begin
        rst = 1'b1;
        flush_e = 1'b0;
        id_rd1 = 32'hDEADBEEF;
        id_rd2 = 32'h12345678;
        id_imm = 32'h10;
        set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, CTRL_NOP);
        #22;
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_stall", stall_f, 0);
        rst = 1'b0;

        // Pass-through
        set_id(1'b1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, C_ADD);
        #1;
        chk("pt_nostall", stall_f, 0);
        tick();
        chk("pt_valid", ex_valid, 1);
        chk("pt_pc", ex_pc, 32'h100);
        chk("pt_pc4", ex_pc4, 32'h104);
        chk("pt_rd1", ex_rd1, 32'hDEADBEEF);
        chk("pt_rd2", ex_rd2, 32'h12345678);
        chk("pt_imm", ex_imm, 32'h10);
        chk("pt_rd", ex_rd, 5);
        chk("pt_rs1", ex_rs1, 1);
        chk("pt_rs2", ex_rs2, 2);
        chk("pt_ctrl", ex_ctrl, C_ADD);
        chk("pt_cnt", bubble_cnt, 0);

        // EX = add x5 (not a load), ID reads x5
        set_id(1'b1, 32'h104, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, C_ADD);
        #1;
        chk("nonload_stall", stall_f, 0);

        // Load-use: lw x5 then add x6,x5,x1
        set_id(1'b1, 32'h200, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, C_LW);
        tick();
        chk("lw_ctrl", ex_ctrl, C_LW);
        set_id(1'b1, 32'h204, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, C_ADD);
        #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_ctrl", ex_ctrl, 0);
        chk("lu_bub_pc", ex_pc, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_released", stall_f, 0);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_add_pc", ex_pc, 32'h204);
        chk("lu_add_nostall", stall_d, 0);

        // rs2 matches but use_rs2=0, then use_rs2=1, then flush on top
        set_id(1'b1, 32'h300, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, C_LW);
        tick();
        set_id(1'b1, 32'h304, 5'd1, 1'b1, 5'd5, 1'b0, 5'd8, C_ADD);
        #1;
        chk("rs2_unused_stall", stall_f, 0);
        id_use_rs2 = 1'b1;
        #1;
        chk("rs2_used_stall", stall_f, 1);
        flush_e = 1'b1;
        #1;
        chk("flush_mask_f", stall_f, 0);
        chk("flush_mask_d", stall_d, 0);
        tick();
        flush_e = 1'b0;
        chk("flush_valid", ex_valid, 0);
        chk("flush_ctrl", ex_ctrl, 0);
        chk("flush_cnt", bubble_cnt, 2);

        // lw x0 with ID reading x0
        set_id(1'b1, 32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, C_LW);
        tick();
        set_id(1'b1, 32'h404, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, C_ADD);
        #1;
        chk("x0_stall", stall_f, 0);

        // Invalid ID instruction: ctrl forced to NOP, no bubble counted
        set_id(1'b0, 32'h408, 5'd3, 1'b0, 5'd4, 1'b0, 5'd9, C_LW);
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_ctrl", ex_ctrl, 0);
        chk("inv_cnt", bubble_cnt, 2);

        // Async reset mid-run with a valid instruction in EX
        set_id(1'b1, 32'h500, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, C_LW);
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        set_id(1'b1, 32'h504, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, C_ADD);
        rst = 1'b1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_pc", ex_pc, 0);
        chk("arst_rd1", ex_rd1, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_cnt", bubble_cnt, 0);
        chk("arst_stall", stall_f, 0);
        tick();
        rst = 1'b0;

        // Saturation with five consecutive flushes
        set_id(1'b1, 32'h600, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, C_ADD);
        flush_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat_%0d", i), bubble_cnt, (i < 3) ? i + 1 : 3);
        end
        flush_e = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
